opnd_sram_loader: RTL
=====================

# opnd_sram_loader

Upstream fill stage for the systolic array. It accepts a narrow operand stream over a VALID/READY handshake and packs the beats into full SRAM rows. It writes matrix A rows into the operand-1 SRAM, then matrix B rows into the operand-2 SRAM. It then issues a one-cycle START to the array and reports completion once the array signals IS_FINISHED.

## Interface
Parameters:
- IN_BWIDTH, 32: stream beat width, i.e. 4 INT8 operands per beat.
- SRAM_BWIDTH, 256: SRAM row width. Must be a multiple of IN_BWIDTH.
- BEATS_PER_ROW, SRAM_BWIDTH/IN_BWIDTH = 8: beats per SRAM row.
- BEATS_LOG2, 3: counter width for the beat counter.
- SRAM_AWIDTH, 10: address width, shared by both operand SRAMs.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- LOAD_START  in  1  one-cycle request to begin a load; ignored unless idle.
- OPND1_NUM_ROWS_in  in  SRAM_AWIDTH+1  matrix A row count, sampled on an accepted LOAD_START.
- OPND2_NUM_ROWS_in  in  SRAM_AWIDTH+1  matrix B row count, sampled on an accepted LOAD_START.
- S_VALID  in  1  stream beat valid.
- S_DATA  in  IN_BWIDTH  stream beat.
- S_READY  out  1  loader accepts a beat this cycle.
- OPND1_SRAM_ADDR_out  out  SRAM_AWIDTH  operand-1 SRAM write address.
- OPND1_SRAM_WEn_out  out  1  operand-1 SRAM write enable, active-low.
- OPND1_SRAM_D_out  out  SRAM_BWIDTH  operand-1 SRAM write data.
- OPND2_SRAM_ADDR_out, OPND2_SRAM_WEn_out, OPND2_SRAM_D_out: same definitions for the operand-2 SRAM.
- SA_START_out  out  1  START pulse to the systolic array.
- SA_IS_FINISHED_in  in  1  array finished flag.
- BUSY_out  out  1  high in every state except IDLE.
- DONE_out  out  1  one-cycle completion pulse.

## Operation
- The FSM has five states: IDLE, LOAD1, LOAD2, KICK, WAIT.
- IDLE: an accepted LOAD_START latches both row counts.
  - Counts above 1<<SRAM_AWIDTH saturate to 1<<SRAM_AWIDTH.
  - Next state is LOAD1 if count1≠0, else LOAD2 if count2≠0, else KICK.
- LOAD1 and LOAD2: S_READY=1, derived from state. A beat is accepted when S_VALID&&S_READY.
  - Packing is little-endian: beat i lands in bits [i*IN_BWIDTH +: IN_BWIDTH], so the first beat occupies the LSBs.
  - The beat counter wraps BEATS_PER_ROW-1→0.
  - On the last beat of a row, the assembled row (including the current beat) is written at the row counter address. The row counter then increments.
  - Row counters start at 0 for each matrix.
  - After the last beat of the last row: LOAD1→(LOAD2 if count2≠0, else KICK); LOAD2→KICK.
  - There is no bubble at row or matrix boundaries.
- KICK: SA_START_out=1 for one cycle, then →WAIT.
- WAIT: when SA_IS_FINISHED_in=1, go →IDLE and pulse DONE_out in that same transition cycle.
- LOAD_START while BUSY_out=1 is ignored; latched counts are unchanged.
- S_DATA is ignored whenever S_READY=0.

## Timing
- All outputs are registered.
- Reset values:
  - S_READY=0, both WEn=1, both ADDR=0, both D=0.
  - SA_START_out=0, BUSY_out=0, DONE_out=0.
  - State IDLE; beat and row counters 0.
- LOAD_START accepted in cycle t: BUSY_out=1 and S_READY=1 from t+1.
- Row write: if the last beat of a row is accepted in cycle t, then WEn=0 with ADDR/D valid in cycle t+1 only, and WEn=1 in t+2 unless another row completes.
  - At peak rate, WEn pulses once every BEATS_PER_ROW cycles.
- Boundary conditions:
  - The final matrix A row write (cycle t+1) overlaps the first matrix B beat acceptance. This is legal because the two SRAMs are separate.
  - The final matrix B beat is accepted in cycle t. S_READY=0 from t+1, when the state is KICK. The matrix B write occurs in t+1, and SA_START_out=1 in t+1.
  - SA_IS_FINISHED_in is sampled only in WAIT. If it is already high on entry to WAIT, DONE_out fires in the first WAIT cycle.
- RST mid-operation:
  - Any partial row is discarded with no write, and no START is issued.
  - All outputs take their reset values on the next edge.

## Configuration
- The macro is SRAM_LOADER_AUTOSTART_EN.
- Defined: the KICK and WAIT states exist, with behaviour as above.
- Undefined:
  - After LOAD2 (or a zero-count load), the FSM goes directly →IDLE and pulses DONE_out.
  - The pulse lands one cycle after the last beat is accepted, coincident with the final write.
  - SA_START_out is tied 0 and SA_IS_FINISHED_in is ignored.

## Test plan
- Reset: hold RST=1 for 3 cycles with S_VALID=1 → all outputs at reset values and no WEn pulse.
- Basic load: counts 2/1 with 24 continuous beats 0x00000000..0x00000017 → three writes:
  - OPND1 addr0 with D[31:0]=0 and D[255:224]=7.
  - OPND1 addr1 with low word 8.
  - OPND2 addr0 with low word 16.
  - SA_START_out is then high 1 cycle. Raising SA_IS_FINISHED_in 10 cycles later gives DONE_out 1 cycle, then BUSY_out=0.
- Gapped stream: same data with S_VALID toggling every cycle → identical SRAM contents and addresses, and each WEn pulse is 1 cycle long.
- Zero counts: 0/0 → KICK on the cycle after LOAD_START, no WEn pulses, and S_READY stays 0.
- Reset mid-row: RST after 5 beats of row 0 → no write. A new 1/1 load then writes OPND1 addr0 from fresh beat 0.
- Busy request: LOAD_START with counts 5/5 issued during LOAD2 of a 1/1 load → ignored; exactly one OPND1 write and one OPND2 write occur.

Source files
------------

// File: rtl/opnd_sram_loader.sv
// Packs a narrow operand stream into SRAM rows: matrix A -> operand-1 SRAM, then matrix B -> operand-2 SRAM.
// Row write lands one cycle after its last beat, with no bubbles; S_READY is high throughout LOAD1/LOAD2.
// SRAM_LOADER_AUTOSTART_EN adds KICK/WAIT (array START pulse, wait for IS_FINISHED); otherwise DONE follows the last write.
module opnd_sram_loader #(
    parameter int IN_BWIDTH     = 32,
    parameter int SRAM_BWIDTH   = 256,
    parameter int BEATS_PER_ROW = SRAM_BWIDTH / IN_BWIDTH,
    parameter int BEATS_LOG2    = 3,
    parameter int SRAM_AWIDTH   = 10
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   LOAD_START,
    input  logic [SRAM_AWIDTH:0]   OPND1_NUM_ROWS_in,
    input  logic [SRAM_AWIDTH:0]   OPND2_NUM_ROWS_in,
    input  logic                   S_VALID,
    input  logic [IN_BWIDTH-1:0]   S_DATA,
    output logic                   S_READY,
    output logic [SRAM_AWIDTH-1:0] OPND1_SRAM_ADDR_out,
    output logic                   OPND1_SRAM_WEn_out,
    output logic [SRAM_BWIDTH-1:0] OPND1_SRAM_D_out,
    output logic [SRAM_AWIDTH-1:0] OPND2_SRAM_ADDR_out,
    output logic                   OPND2_SRAM_WEn_out,
    output logic [SRAM_BWIDTH-1:0] OPND2_SRAM_D_out,
    output logic                   SA_START_out,
    input  logic                   SA_IS_FINISHED_in,
    output logic                   BUSY_out,
    output logic                   DONE_out
);

`ifdef SRAM_LOADER_AUTOSTART_EN
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD1, ST_LOAD2, ST_KICK, ST_WAIT} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD1, ST_LOAD2} state_t;
    logic unused_finished;
    assign unused_finished = SA_IS_FINISHED_in;
`endif

    localparam int unsigned             MAX_ROWS_I = 1 << SRAM_AWIDTH;
    localparam logic [SRAM_AWIDTH:0]    MAX_ROWS   = MAX_ROWS_I[SRAM_AWIDTH:0];
    localparam logic [SRAM_AWIDTH:0]    ROW_ONE    = {{SRAM_AWIDTH{1'b0}}, 1'b1};
    localparam logic [BEATS_LOG2-1:0]   BEAT_ONE   = {{(BEATS_LOG2-1){1'b0}}, 1'b1};
    localparam logic [BEATS_LOG2-1:0]   LAST_BEAT  = BEATS_LOG2'(BEATS_PER_ROW - 1);

    state_t                 state_q, state_d;
    logic [BEATS_LOG2-1:0]  beat_q;
    logic [SRAM_AWIDTH:0]   row_cnt_q, cnt1_q, cnt2_q;
    logic [SRAM_BWIDTH-1:0] row_q, row_d;
    logic                   s_ready_q, busy_q, done_q, done_d, sa_start_q;
    logic [SRAM_AWIDTH-1:0] op1_addr_q, op2_addr_q;
    logic                   op1_wen_q, op2_wen_q;
    logic [SRAM_BWIDTH-1:0] op1_d_q, op2_d_q;

    logic                   accept, row_done, mat_done;
    logic [SRAM_AWIDTH:0]   cnt1_sat, cnt2_sat, last_row;

    always_comb begin
        accept   = s_ready_q & S_VALID;
        row_done = accept && (beat_q == LAST_BEAT);
        last_row = ((state_q == ST_LOAD2) ? cnt2_q : cnt1_q) - ROW_ONE;
        mat_done = row_done && (row_cnt_q == last_row);
        cnt1_sat = (OPND1_NUM_ROWS_in > MAX_ROWS) ? MAX_ROWS : OPND1_NUM_ROWS_in;
        cnt2_sat = (OPND2_NUM_ROWS_in > MAX_ROWS) ? MAX_ROWS : OPND2_NUM_ROWS_in;
        // Current beat is merged here so the last beat goes straight into the write data.
        row_d = row_q;
        row_d[int'(beat_q) * IN_BWIDTH +: IN_BWIDTH] = S_DATA;

        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (LOAD_START) begin
                if (cnt1_sat != '0)      state_d = ST_LOAD1;
                else if (cnt2_sat != '0) state_d = ST_LOAD2;
`ifdef SRAM_LOADER_AUTOSTART_EN
                else                     state_d = ST_KICK;
`else
                else                     done_d  = 1'b1;
`endif
            end
            ST_LOAD1: if (mat_done) begin
                if (cnt2_q != '0) state_d = ST_LOAD2;
`ifdef SRAM_LOADER_AUTOSTART_EN
                else              state_d = ST_KICK;
`else
                else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
`endif
            end
            ST_LOAD2: if (mat_done) begin
`ifdef SRAM_LOADER_AUTOSTART_EN
                state_d = ST_KICK;
`else
                state_d = ST_IDLE;
                done_d  = 1'b1;
`endif
            end
`ifdef SRAM_LOADER_AUTOSTART_EN
            ST_KICK: state_d = ST_WAIT;
            ST_WAIT: if (SA_IS_FINISHED_in) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            row_cnt_q  <= '0;
            cnt1_q     <= '0;
            cnt2_q     <= '0;
            row_q      <= '0;
            s_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sa_start_q <= 1'b0;
            op1_addr_q <= '0;
            op2_addr_q <= '0;
            op1_wen_q  <= 1'b1;
            op2_wen_q  <= 1'b1;
            op1_d_q    <= '0;
            op2_d_q    <= '0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= (state_d == ST_LOAD1) || (state_d == ST_LOAD2);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= done_d;
`ifdef SRAM_LOADER_AUTOSTART_EN
            sa_start_q <= (state_d == ST_KICK);
`else
            sa_start_q <= 1'b0;
`endif
            op1_wen_q <= 1'b1;
            op2_wen_q <= 1'b1;
            if ((state_q == ST_IDLE) && LOAD_START) begin
                cnt1_q    <= cnt1_sat;
                cnt2_q    <= cnt2_sat;
                row_cnt_q <= '0;
                beat_q    <= '0;
            end
            if (accept) begin
                row_q  <= row_d;
                beat_q <= row_done ? '0 : beat_q + BEAT_ONE;
                if (row_done) begin
                    row_cnt_q <= mat_done ? '0 : row_cnt_q + ROW_ONE;
                    if (state_q == ST_LOAD1) begin
                        op1_wen_q  <= 1'b0;
                        op1_addr_q <= row_cnt_q[SRAM_AWIDTH-1:0];
                        op1_d_q    <= row_d;
                    end else begin
                        op2_wen_q  <= 1'b0;
                        op2_addr_q <= row_cnt_q[SRAM_AWIDTH-1:0];
                        op2_d_q    <= row_d;
                    end
                end
            end
        end
    end

    assign S_READY             = s_ready_q;
    assign BUSY_out            = busy_q;
    assign DONE_out            = done_q;
    assign SA_START_out        = sa_start_q;
    assign OPND1_SRAM_ADDR_out = op1_addr_q;
    assign OPND1_SRAM_WEn_out  = op1_wen_q;
    assign OPND1_SRAM_D_out    = op1_d_q;
    assign OPND2_SRAM_ADDR_out = op2_addr_q;
    assign OPND2_SRAM_WEn_out  = op2_wen_q;
    assign OPND2_SRAM_D_out    = op2_d_q;

endmodule
